// File: rtl/sound_effect_sequencer.sv
// Sound-effect sequencer: turns fire/explosion event pulses into timed note
// sequences from a fixed table and arbitrates them (explosion > fire > thrust)
// ahead of the square-wave tone generator.
//
// Ports:
//   clock100     : system clock (100 MHz)
//   reset        : synchronous, active-high reset
//   fire_trig    : rising edge starts the fire effect
//   explode_trig : rising edge starts the explosion effect
//   thrust_on    : level, thrust drone while no sequenced effect plays
//   mute         : level, forces audEn low without disturbing sequencing
//   period       : tone period in 10 ns units, 0 when silent
//   audEn        : audio enable to the tone generator / amplifier
//   busy         : high while fire or explosion plays
//   effect_id    : 0=silent, 1=fire, 2=explosion, 3=thrust
//
// state | meaning
// IDLE  | no sequenced effect; output is thrust drone or silence
// PLAY  | playing note note_idx of the fire or explosion table
module sound_effect_sequencer #(
  parameter int          TICK_DIV      = 100000,
  parameter logic [31:0] THRUST_PERIOD = 32'd1000000
) (
  input  logic        clock100,
  input  logic        reset,
  input  logic        fire_trig,
  input  logic        explode_trig,
  input  logic        thrust_on,
  input  logic        mute,
  output logic [31:0] period,
  output logic        audEn,
  output logic        busy,
  output logic [1:0]  effect_id
);

  localparam int CW = $clog2(TICK_DIV);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t        state, state_n;
  logic          effect_expl, effect_expl_n;  // 0 = fire, 1 = explosion
  logic [1:0]    note_idx, note_idx_n;
  logic [6:0]    remaining, remaining_n;
  logic [CW-1:0] tick_cnt, tick_cnt_n;
  logic          fire_prev, explode_prev;
  logic          fire_start, explode_start, tick;
  logic [31:0]   period_n;
  logic          aud_en_n, busy_n;
  logic [1:0]    effect_id_n;

  function automatic logic [31:0] note_period(input logic expl, input logic [1:0] idx);
    if (expl) begin
      case (idx)
        2'd0:    return 32'd400000;
        2'd1:    return 32'd500000;
        2'd2:    return 32'd600000;
        default: return 32'd800000;
      endcase
    end else begin
      case (idx)
        2'd0:    return 32'd50000;
        2'd1:    return 32'd75000;
        default: return 32'd100000;
      endcase
    end
  endfunction

  function automatic logic [6:0] note_dur(input logic expl, input logic [1:0] idx);
    if (expl) return (idx == 2'd3) ? 7'd120 : 7'd60;
    else      return 7'd30;
  endfunction

  always_ff @(posedge clock100) begin
    if (reset) begin
      state        <= IDLE;
      effect_expl  <= 1'b0;
      note_idx     <= '0;
      remaining    <= '0;
      tick_cnt     <= '0;
      fire_prev    <= 1'b0;
      explode_prev <= 1'b0;
      period       <= '0;
      audEn        <= 1'b0;
      busy         <= 1'b0;
      effect_id    <= '0;
    end else begin
      state        <= state_n;
      effect_expl  <= effect_expl_n;
      note_idx     <= note_idx_n;
      remaining    <= remaining_n;
      tick_cnt     <= tick_cnt_n;
      fire_prev    <= fire_trig;
      explode_prev <= explode_trig;
      period       <= period_n;
      audEn        <= aud_en_n;
      busy         <= busy_n;
      effect_id    <= effect_id_n;
    end
  end

  always_comb begin
    fire_start    = fire_trig & ~fire_prev;
    explode_start = explode_trig & ~explode_prev;
    tick          = (tick_cnt == CW'(TICK_DIV - 1));

    state_n       = state;
    effect_expl_n = effect_expl;
    note_idx_n    = note_idx;
    remaining_n   = remaining;
    tick_cnt_n    = tick ? '0 : tick_cnt + 1'b1;

    // A start outranks a coincident tick; fire cannot break into an explosion.
    if (explode_start) begin
      state_n       = PLAY;
      effect_expl_n = 1'b1;
      note_idx_n    = 2'd0;
      remaining_n   = note_dur(1'b1, 2'd0);
      tick_cnt_n    = '0;
    end else if (fire_start && (state == IDLE || !effect_expl)) begin
      state_n       = PLAY;
      effect_expl_n = 1'b0;
      note_idx_n    = 2'd0;
      remaining_n   = note_dur(1'b0, 2'd0);
      tick_cnt_n    = '0;
    end else if (state == PLAY && tick) begin
      if (remaining > 7'd1) begin
        remaining_n = remaining - 7'd1;
      end else if (note_idx == (effect_expl ? 2'd3 : 2'd2)) begin
        state_n = IDLE;
      end else begin
        note_idx_n  = note_idx + 2'd1;
        remaining_n = note_dur(effect_expl, note_idx + 2'd1);
      end
    end

    // Outputs are registered from the next state so they track it with one cycle latency.
    period_n    = '0;
    busy_n      = 1'b0;
    effect_id_n = 2'd0;
    if (state_n == PLAY) begin
      period_n    = note_period(effect_expl_n, note_idx_n);
      busy_n      = 1'b1;
      effect_id_n = effect_expl_n ? 2'd2 : 2'd1;
    end else if (thrust_on) begin
      period_n    = THRUST_PERIOD;
      effect_id_n = 2'd3;
    end
    aud_en_n = (period_n != '0) & ~mute;
  end

endmodule

// File: tb/tb_sound_effect_sequencer.sv
module tb_sound_effect_sequencer;

  logic        clock100;
  logic        reset;
  logic        fire_trig, explode_trig, thrust_on, mute;
  logic [31:0] period;
  logic        audEn, busy;
  logic [1:0]  effect_id;

  int n_checks = 0;
  int n_pass   = 0;

  sound_effect_sequencer #(.TICK_DIV(10), .THRUST_PERIOD(32'd1000000)) dut (
    .clock100    (clock100),
    .reset       (reset),
    .fire_trig   (fire_trig),
    .explode_trig(explode_trig),
    .thrust_on   (thrust_on),
    .mute        (mute),
    .period      (period),
    .audEn       (audEn),
    .busy        (busy),
    .effect_id   (effect_id)
  );

  initial clock100 = 1'b0;
  always #5 clock100 = ~clock100;

  typedef struct {
    logic        fire;
    logic        expl;
    logic        thrust;
    logic        mute;
    int          wait_cyc;
    logic [31:0] p;
    logic        a;
    logic        b;
    logic [1:0]  id;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic f, input logic e, input logic t, input logic m, input int w,
                     input logic [31:0] p, input logic a, input logic b, input logic [1:0] id);
    vec_t v;
    v.fire = f; v.expl = e; v.thrust = t; v.mute = m; v.wait_cyc = w;
    v.p = p; v.a = a; v.b = b; v.id = id;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] p, input logic a,
                       input logic b, input logic [1:0] id);
    n_checks++;
    if (period === p && audEn === a && busy === b && effect_id === id) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got period=%0d audEn=%0b busy=%0b effect_id=%0d, want period=%0d audEn=%0b busy=%0b effect_id=%0d",
               name, period, audEn, busy, effect_id, p, a, b, id);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock100);
  endtask

  initial begin
    // Inputs applied at a negedge, then wait_cyc negedges, then compare.
    // d = negedges since a trigger was driven; note k change at start+dur shows at d=dur+1.
    // fire: single pulse, note boundaries 300/600/900
    add(1,0,0,0,   1,  32'd50000, 1,1,2'd1);
    add(0,0,0,0, 299,  32'd50000, 1,1,2'd1);
    add(0,0,0,0,   1,  32'd75000, 1,1,2'd1);
    add(0,0,0,0, 299,  32'd75000, 1,1,2'd1);
    add(0,0,0,0,   1, 32'd100000, 1,1,2'd1);
    add(0,0,0,0, 299, 32'd100000, 1,1,2'd1);
    add(0,0,0,0,   1,         0, 0,0,2'd0);
    // thrust drone, fire over thrust, drone resumes
    add(0,0,1,0,   1, 32'd1000000, 1,0,2'd3);
    add(1,0,1,0,   1,   32'd50000, 1,1,2'd1);
    add(0,0,1,0, 899,  32'd100000, 1,1,2'd1);
    add(0,0,1,0,   1, 32'd1000000, 1,0,2'd3);
    add(0,0,0,0,   1,           0, 0,0,2'd0);
    // mute during fire
    add(1,0,0,1,   1,  32'd50000, 0,1,2'd1);
    add(0,0,0,1, 300,  32'd75000, 0,1,2'd1);
    add(0,0,0,1, 300, 32'd100000, 0,1,2'd1);
    add(0,0,0,0,   1, 32'd100000, 1,1,2'd1);
    add(0,0,0,0, 299,          0, 0,0,2'd0);
    // explosion trigger held for 2000 cycles
    add(0,1,0,0,   1, 32'd400000, 1,1,2'd2);
    add(0,1,0,0, 600, 32'd500000, 1,1,2'd2);
    add(0,1,0,0, 600, 32'd600000, 1,1,2'd2);
    add(0,1,0,0, 600, 32'd800000, 1,1,2'd2);
    add(0,1,0,0, 199, 32'd800000, 1,1,2'd2);
    add(0,0,0,0,1000, 32'd800000, 1,1,2'd2);
    add(0,0,0,0,   1,          0, 0,0,2'd0);
    // fire pulse at cycle 100 of explosion is ignored
    add(0,1,0,0,   1, 32'd400000, 1,1,2'd2);
    add(0,0,0,0,  99, 32'd400000, 1,1,2'd2);
    add(1,0,0,0,   1, 32'd400000, 1,1,2'd2);
    add(0,0,0,0, 499, 32'd400000, 1,1,2'd2);
    add(0,0,0,0,   1, 32'd500000, 1,1,2'd2);
    add(0,0,0,0,2400,          0, 0,0,2'd0);
    // explosion at cycle 100 of fire takes over with fresh timing
    add(1,0,0,0,   1,  32'd50000, 1,1,2'd1);
    add(0,0,0,0,  99,  32'd50000, 1,1,2'd1);
    add(0,1,0,0,   1, 32'd400000, 1,1,2'd2);
    add(0,0,0,0, 599, 32'd400000, 1,1,2'd2);
    add(0,0,0,0,   1, 32'd500000, 1,1,2'd2);

    reset = 1'b1; fire_trig = 0; explode_trig = 0; thrust_on = 0; mute = 0;
    step(3);
    check("reset", 0, 0, 0, 2'd0);
    reset = 1'b0;
    step(2);
    check("idle", 0, 0, 0, 2'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      fire_trig    = vecs[i].fire;
      explode_trig = vecs[i].expl;
      thrust_on    = vecs[i].thrust;
      mute         = vecs[i].mute;
      step(vecs[i].wait_cyc);
      check($sformatf("vec%0d", i), vecs[i].p, vecs[i].a, vecs[i].b, vecs[i].id);
    end

    // reset mid-explosion (explosion still playing from the last vector)
    reset = 1'b1;
    step(1);
    check("reset_mid_expl", 0, 0, 0, 2'd0);
    reset = 1'b0;
    step(1);
    check("after_reset", 0, 0, 0, 2'd0);

    // simultaneous fire and explosion: explosion wins
    fire_trig = 1; explode_trig = 1;
    step(1);
    check("both_start", 32'd400000, 1, 1, 2'd2);
    fire_trig = 0; explode_trig = 0;
    step(599);
    check("both_note0_end", 32'd400000, 1, 1, 2'd2);
    step(1);
    check("both_note1", 32'd500000, 1, 1, 2'd2);

    // fire restart during fire returns to note 0
    reset = 1'b1; step(1); reset = 1'b0;
    fire_trig = 1; step(1); fire_trig = 0;
    step(349);
    check("fire_note1", 32'd75000, 1, 1, 2'd1);
    fire_trig = 1; step(1); fire_trig = 0;
    check("fire_restart", 32'd50000, 1, 1, 2'd1);
    step(299);
    check("fire_restart_end0", 32'd50000, 1, 1, 2'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
